// File: rtl/dmi_resp_buffer_pkg.sv
// dmi_resp_buffer_pkg: shared widths, DMI response codes and buffer FSM states.
package dmi_resp_buffer_pkg;

   localparam int DMI_RESP_W = 34;
   localparam int CNT_W      = 16;

   // DMI response codes carried in the low two bits of each entry
   localparam logic [1:0] RESP_OK     = 2'b00;
   localparam logic [1:0] RESP_FAILED = 2'b10;
   localparam logic [1:0] RESP_BUSY   = 2'b11;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      WAIT  = 2'd2
   } state_e;

endpackage

// File: rtl/dmi_resp_buffer_sat_cnt.sv
// dmi_resp_buffer_sat_cnt: W-bit incrementer that sticks at all-ones.
module dmi_resp_buffer_sat_cnt
   import dmi_resp_buffer_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   // count events, holding at the maximum instead of wrapping
   always_ff @(posedge clk_i) begin
      if (rst_i)                     cnt_q <= '0;
      else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + W'(1);
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dmi_resp_buffer.sv
// dmi_resp_buffer: clearable DEPTH-entry response FIFO feeding the DMI
// response CDC source port. Statistics counters are built only when
// DMI_RESP_BUFFER_STATS_EN is defined; otherwise they read zero.
module dmi_resp_buffer
   import dmi_resp_buffer_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = DMI_RESP_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              cdc_clear_pending_i,
   output logic              cdc_clear_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CNT_W-1:0]  drop_cnt_o,
   output logic [CNT_W-1:0]  err_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   state_e            state_q;
   logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]     cnt_q;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic full, empty, push, pop, wr_en, rd_en;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);

   // Handshake flags come from registered state only; while flushing the
   // input side always accepts so the debug module never stalls.
   assign in_ready_o  = (state_q != RUN) || !full;
   assign out_valid_o = (state_q == RUN) && !empty;
   assign cdc_clear_o = (state_q == FLUSH);
   assign out_data_o  = mem_q[rd_ptr_q];

   assign push  = in_valid_i && in_ready_o;
   assign pop   = out_valid_o && out_ready_i;
   // a clear overrides storage: the pop still handshakes but pointers zero
   assign wr_en = push && (state_q == RUN) && !clear_i;
   assign rd_en = pop && !clear_i;

   // clear control: clear_i wins from any state, then wait on the crossing
   always_ff @(posedge clk_i) begin
      if (rst_i)        state_q <= RUN;
      else if (clear_i) state_q <= FLUSH;
      else begin
         case (state_q)
            FLUSH:   if (cdc_clear_pending_i)  state_q <= WAIT;
            WAIT:    if (!cdc_clear_pending_i) state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   // storage, pointers and occupancy count
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data_i;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({wr_en, rd_en})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

`ifdef DMI_RESP_BUFFER_STATS_EN
   // anything accepted while flushing, or in the clear cycle, is lost
   logic drop, err_inc;
   assign drop    = push && ((state_q != RUN) || clear_i);
   assign err_inc = wr_en && in_data_i[1];

   dmi_resp_buffer_sat_cnt #(.W(CNT_W)) u_drop_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (drop),
      .cnt_o (drop_cnt_o)
   );

   dmi_resp_buffer_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (err_inc),
      .cnt_o (err_cnt_o)
   );
`else
   assign drop_cnt_o = '0;
   assign err_cnt_o  = '0;
`endif

endmodule
